// File: rtl/apb_req_arbiter_pkg.sv
// Shared types for the APB request arbiter: FSM state encoding and slave-select width helper.
package apb_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apbState_e;

  // Width of the slave index field taken from the address; never narrower than one bit.
  function automatic int selWidth(input int numSlaves);
    return (numSlaves > 1) ? $clog2(numSlaves) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: first valid requester at or after rrPtr_i, wrapping around.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rrPtr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               anyValid_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest valid requester is the last writer.
  always_comb begin
    grant_o    = '0;
    anyValid_o = 1'b0;
    cand       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rrPtr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (valid_i[cand]) begin
        grant_o    = IDX_W'(cand);
        anyValid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB master: round-robin grant, SETUP/ACCESS sequencing, one-cycle response.
// Optional ACCESS-phase timeout is compiled in with APB_REQ_ARBITER_TIMEOUT_EN.
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int APB_NUM_SLAVES = 8,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_write_i,
  input  logic [NUM_REQ*32-1:0]        req_addr_i,
  input  logic [NUM_REQ*32-1:0]        req_wdata_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [31:0]                  rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic [APB_NUM_SLAVES-1:0]    PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [31:0]                  PADDR,
  output logic [31:0]                  PWDATA,
  input  logic [APB_NUM_SLAVES*32-1:0] PRDATA,
  input  logic [APB_NUM_SLAVES-1:0]    PREADY,
  input  logic [APB_NUM_SLAVES-1:0]    PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SEL_W = selWidth(APB_NUM_SLAVES);

  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apbState_e        state_q, state_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d, grant_q, grant_d;
  logic [SEL_W-1:0] slvIdx_q, slvIdx_d;
  logic             write_q, write_d, err_q, err_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic [IDX_W-1:0] arbGrant, nextPtr;
  logic             arbAny, reqWrite, decErr, slvReady, slvErr;
  logic [31:0]      reqAddr, reqWdata, slvRdata;
  logic [SEL_W-1:0] reqIdx;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) uRrArbiter (
    .valid_i    (req_valid_i),
    .rrPtr_i    (rrPtr_q),
    .grant_o    (arbGrant),
    .anyValid_o (arbAny)
  );

  always_comb begin
    reqWrite = 1'b0;
    reqAddr  = '0;
    reqWdata = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (arbGrant == IDX_W'(r)) begin
        reqWrite = req_write_i[r];
        reqAddr  = req_addr_i[r*32 +: 32];
        reqWdata = req_wdata_i[r*32 +: 32];
      end
    end
  end

  assign reqIdx  = reqAddr[APB_ADDR_WIDTH +: SEL_W];
  assign decErr  = int'(reqIdx) >= APB_NUM_SLAVES;
  assign nextPtr = (int'(arbGrant) == NUM_REQ - 1) ? '0 : arbGrant + IDX_W'(1);

  always_comb begin
    slvReady = 1'b0;
    slvErr   = 1'b0;
    slvRdata = '0;
    for (int s = 0; s < APB_NUM_SLAVES; s++) begin
      if (slvIdx_q == SEL_W'(s)) begin
        slvReady = PREADY[s];
        slvErr   = PSLVERR[s];
        slvRdata = PRDATA[s*32 +: 32];
      end
    end
  end

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) waitCnt_q <= '0;
    else       waitCnt_q <= waitCnt_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    grant_d  = grant_q;
    slvIdx_d = slvIdx_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    waitCnt_d = waitCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (arbAny) begin
          grant_d  = arbGrant;
          rrPtr_d  = nextPtr;
          write_d  = reqWrite;
          addr_d   = reqAddr;
          wdata_d  = reqWdata;
          slvIdx_d = reqIdx;
          // Unmapped slave index: answer with an error and never touch the bus.
          if (decErr) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        waitCnt_d = CNT_W'(1);
`endif
      end
      ACCESS: begin
        if (slvReady) begin
          rdata_d = write_q ? '0 : slvRdata;
          err_d   = slvErr;
          state_d = RESP;
        end
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        else if (waitCnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rrPtr_q  <= '0;
      grant_q  <= '0;
      slvIdx_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      grant_q  <= grant_d;
      slvIdx_q <= slvIdx_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Accept is withheld while reset is asserted so nothing is granted on the reset edge.
  always_comb begin
    PSEL        = '0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int s = 0; s < APB_NUM_SLAVES; s++) begin
      PSEL[s] = ((state_q == SETUP) || (state_q == ACCESS)) && (slvIdx_q == SEL_W'(s));
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      req_ready_o[r] = (state_q == IDLE) && !rst_i && arbAny && (arbGrant == IDX_W'(r));
      rsp_valid_o[r] = (state_q == RESP) && (grant_q == IDX_W'(r));
    end
  end

  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = write_q;
  assign PADDR       = addr_q;
  assign PWDATA      = wdata_q;
  assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == RESP) && err_q;

endmodule
